// File: rtl/frame_sequencer_pkg.sv
// Shared types for the frame sequencer: state encoding, VGA source codes
// and the Moore decode from state to strobes.
package frame_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_IDLE       = 4'd2,
    ST_REG        = 4'd3,
    ST_APPLY      = 4'd4,
    ST_DRAW_MAP   = 4'd5,
    ST_DRAW_LINK  = 4'd6,
    ST_DRAW_ENEMY = 4'd7,
    ST_GAME_OVER  = 4'd8
  } state_e;

  localparam logic [1:0] VGA_SEL_MAP   = 2'd0;
  localparam logic [1:0] VGA_SEL_LINK  = 2'd1;
  localparam logic [1:0] VGA_SEL_ENEMY = 2'd2;
  localparam logic [1:0] VGA_SEL_NONE  = 2'd3;

  localparam int WD_W = 17;

  typedef struct packed {
    logic       init;
    logic       idle;
    logic       reg_action;
    logic       apply_action;
    logic       draw_map;
    logic       draw_link;
    logic       game_over;
    logic [1:0] vga_sel;
  } strobes_t;

  // Per-enemy draw enables are decoded in the top, since their width depends on N_ENEMY.
  function automatic strobes_t decode_state(state_e s);
    strobes_t o;
    o         = '0;
    o.vga_sel = VGA_SEL_NONE;
    case (s)
      ST_INIT:       o.init         = 1'b1;
      ST_IDLE:       o.idle         = 1'b1;
      ST_REG:        o.reg_action   = 1'b1;
      ST_APPLY:      o.apply_action = 1'b1;
      ST_DRAW_MAP: begin
        o.draw_map = 1'b1;
        o.vga_sel  = VGA_SEL_MAP;
      end
      ST_DRAW_LINK: begin
        o.draw_link = 1'b1;
        o.vga_sel   = VGA_SEL_LINK;
      end
      ST_DRAW_ENEMY: o.vga_sel      = VGA_SEL_ENEMY;
      ST_GAME_OVER:  o.game_over    = 1'b1;
      default:       ;
    endcase
    return o;
  endfunction

  function automatic logic is_draw_state(state_e s);
    return (s == ST_DRAW_MAP) || (s == ST_DRAW_LINK) || (s == ST_DRAW_ENEMY);
  endfunction

endpackage

// File: rtl/frame_sequencer_watchdog.sv
// Draw-state watchdog: counts cycles spent in the current draw state and
// flags expiry on the TIMEOUT-th cycle so the sequencer can force an advance.
module draw_watchdog
  import frame_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 131071
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame game sequencer: input capture, movement, then map/player/enemy
// draws on the shared VGA write port, with game-over and overrun tracking.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int N_ENEMY      = 2,
  parameter int APPLY_CYCLES = 1,
  parameter int DRAW_TIMEOUT = 131071
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               c_start,
  input  logic               frame_tick,
  input  logic [2:0]         hp,
  input  logic               map_draw_done,
  input  logic               link_draw_done,
  input  logic [N_ENEMY-1:0] enemy_draw_done,
  output logic               init,
  output logic               idle,
  output logic               reg_action,
  output logic               apply_action,
  output logic               draw_map,
  output logic               draw_link,
  output logic [N_ENEMY-1:0] draw_enemy,
  output logic [1:0]         vga_sel,
  output logic [1:0]         enemy_idx,
  output logic               game_over,
  output logic               frame_overrun,
  output logic               timeout_err
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         apply_cnt_q, apply_cnt_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  strobes_t           out_q;
  logic [N_ENEMY-1:0] enemy_en_q, enemy_en_d;

  logic in_draw, done_sel, wd_expired, advance;

  // Done handshake: a client's done level is honoured only while its own
  // draw state (and, for enemies, its own index) is active; the enable drops
  // on the cycle after done is seen, and a lingering done is ignored.
  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      ST_DRAW_MAP:  done_sel = map_draw_done;
      ST_DRAW_LINK: done_sel = link_draw_done;
      default:      ;
    endcase
    for (int i = 0; i < N_ENEMY; i++) begin
      if (state_q == ST_DRAW_ENEMY && idx_q == 2'(i)) done_sel = enemy_draw_done[i];
    end
  end

  assign in_draw = is_draw_state(state_q);
  assign advance = in_draw && (done_sel || wd_expired);

  draw_watchdog #(.TIMEOUT(DRAW_TIMEOUT)) u_watchdog (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .clear_i   (!in_draw || advance),
    .enable_i  (in_draw),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    apply_cnt_d = apply_cnt_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_INIT:       state_d = ST_WAIT_START;
      ST_WAIT_START: if (c_start) state_d = ST_IDLE;
      ST_IDLE: begin
        if (hp == 3'd0)      state_d = ST_GAME_OVER;
        else if (frame_tick) state_d = ST_REG;
      end
      ST_REG: begin
        state_d     = ST_APPLY;
        apply_cnt_d = 4'(APPLY_CYCLES - 1);
      end
      ST_APPLY: begin
        if (apply_cnt_q == 4'd0) state_d = ST_DRAW_MAP;
        else                     apply_cnt_d = apply_cnt_q - 4'd1;
      end
      ST_DRAW_MAP:  if (advance) state_d = ST_DRAW_LINK;
      ST_DRAW_LINK: begin
        if (advance) begin
          state_d = ST_DRAW_ENEMY;
          idx_d   = 2'd0;
        end
      end
      ST_DRAW_ENEMY: begin
        if (advance) begin
          if (idx_q == 2'(N_ENEMY - 1)) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_GAME_OVER: if (c_start) state_d = ST_INIT;
      default:      state_d = ST_INIT;
    endcase

    // A tick mid-frame is dropped; only the sticky flag records it.
    if (frame_tick && (state_q inside {ST_REG, ST_APPLY, ST_DRAW_MAP, ST_DRAW_LINK, ST_DRAW_ENEMY}))
      overrun_d = 1'b1;
    if (advance && !done_sel) timeout_d = 1'b1;
    if (state_d == ST_INIT) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end

    for (int i = 0; i < N_ENEMY; i++) begin
      enemy_en_d[i] = (state_d == ST_DRAW_ENEMY) && (idx_d == 2'(i));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      idx_q       <= 2'd0;
      apply_cnt_q <= 4'd0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      out_q       <= decode_state(ST_INIT);
      enemy_en_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      apply_cnt_q <= apply_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      out_q       <= decode_state(state_d);
      enemy_en_q  <= enemy_en_d;
    end
  end

  assign init          = out_q.init;
  assign idle          = out_q.idle;
  assign reg_action    = out_q.reg_action;
  assign apply_action  = out_q.apply_action;
  assign draw_map      = out_q.draw_map;
  assign draw_link     = out_q.draw_link;
  assign draw_enemy    = enemy_en_q;
  assign vga_sel       = out_q.vga_sel;
  assign enemy_idx     = idx_q;
  assign game_over     = out_q.game_over;
  assign frame_overrun = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: frame-scenario table, hand-written
// corner sequences and random stimulus against a frame-step reference model.
module tb_frame_sequencer;

  localparam int NE        = 2;
  localparam int APPLY     = 1;
  localparam int TMO       = 1000;
  localparam int STEP_MAP  = APPLY + 1;
  localparam int STEP_LINK = APPLY + 2;
  localparam int STEP_E0   = APPLY + 3;
  localparam int STEP_LAST = STEP_E0 + NE - 1;

  localparam logic [14:0] RESET_VEC = {1'b1, 5'b00000, 2'b00, 2'b11, 2'b00, 3'b000};

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          c_start = 1'b0;
  logic          frame_tick = 1'b0;
  logic [2:0]    hp = 3'd7;
  logic          map_draw_done, link_draw_done;
  logic [NE-1:0] enemy_draw_done;
  logic          init, idle, reg_action, apply_action, draw_map, draw_link;
  logic [NE-1:0] draw_enemy;
  logic [1:0]    vga_sel, enemy_idx;
  logic          game_over, frame_overrun, timeout_err;

  frame_sequencer #(.N_ENEMY(NE), .APPLY_CYCLES(APPLY), .DRAW_TIMEOUT(TMO)) dut (
    .clock(clock), .resetn(resetn), .c_start(c_start), .frame_tick(frame_tick), .hp(hp),
    .map_draw_done(map_draw_done), .link_draw_done(link_draw_done),
    .enemy_draw_done(enemy_draw_done), .init(init), .idle(idle), .reg_action(reg_action),
    .apply_action(apply_action), .draw_map(draw_map), .draw_link(draw_link),
    .draw_enemy(draw_enemy), .vga_sel(vga_sel), .enemy_idx(enemy_idx), .game_over(game_over),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  logic [14:0] dut_vec;
  assign dut_vec = {init, idle, reg_action, apply_action, draw_map, draw_link,
                    draw_enemy, vga_sel, enemy_idx, game_over, frame_overrun, timeout_err};

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is a list of steps: 0 = capture, 1..APPLY = apply, then map,
  // player and one step per enemy. Draw steps end on done or after TMO cycles.
  typedef enum {M_INIT, M_WAIT, M_IDLE, M_FRAME, M_OVER} mmode_t;
  mmode_t m_mode = M_INIT;
  int     m_step = 0;
  int     m_age  = 0;
  bit     m_ovr  = 0;
  bit     m_tmo  = 0;
  bit     m_dn;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_INIT; m_step = 0; m_age = 0; m_ovr = 0; m_tmo = 0;
    end else begin
      case (m_mode)
        M_INIT: m_mode = M_WAIT;
        M_WAIT: if (c_start) m_mode = M_IDLE;
        M_IDLE: begin
          if (hp == 3'd0) m_mode = M_OVER;
          else if (frame_tick) begin m_mode = M_FRAME; m_step = 0; m_age = 0; end
        end
        M_FRAME: begin
          if (frame_tick) m_ovr = 1;
          if (m_step < STEP_MAP) begin
            m_step++; m_age = 0;
          end else begin
            if (m_step == STEP_MAP)       m_dn = map_draw_done;
            else if (m_step == STEP_LINK) m_dn = link_draw_done;
            else                          m_dn = enemy_draw_done[m_step - STEP_E0];
            if (m_dn || m_age == TMO - 1) begin
              if (!m_dn) m_tmo = 1;
              if (m_step == STEP_LAST) m_mode = M_IDLE;
              else m_step++;
              m_age = 0;
            end else begin
              m_age++;
            end
          end
        end
        M_OVER: if (c_start) begin m_mode = M_INIT; m_ovr = 0; m_tmo = 0; end
        default: m_mode = M_INIT;
      endcase
    end
  end

  function automatic logic [14:0] model_vec();
    logic [1:0] de, vs, ix;
    logic       fr;
    fr = (m_mode == M_FRAME);
    de = 2'b00; vs = 2'd3; ix = 2'd0;
    if (fr && m_step == STEP_MAP)  vs = 2'd0;
    if (fr && m_step == STEP_LINK) vs = 2'd1;
    if (fr && m_step >= STEP_E0) begin
      vs = 2'd2;
      ix = 2'(m_step - STEP_E0);
      de = 2'b01 << ix;
    end
    return {m_mode == M_INIT, m_mode == M_IDLE, fr && m_step == 0,
            fr && m_step >= 1 && m_step <= APPLY, fr && m_step == STEP_MAP,
            fr && m_step == STEP_LINK, de, vs, ix, m_mode == M_OVER, m_ovr, m_tmo};
  endfunction

  always @(negedge clock) begin
    if (chk_en) check("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
  end

  // ---------------- draw clients ----------------
  // Client k raises done on the d-th enabled cycle (d = 0 means never) and
  // holds it one extra cycle after its enable drops.
  int   cfg_d[4];
  int   cur_d[4];
  int   cnt[4];
  bit   dv[4];
  bit   rand_mode = 0;
  logic [3:0] en_v;

  always @(negedge clock) begin
    en_v = {draw_enemy[1], draw_enemy[0], draw_link, draw_map};
    for (int k = 0; k < 4; k++) begin
      if (en_v[k]) begin
        cnt[k]++;
        if (cnt[k] == 1) cur_d[k] = rand_mode ? int'($urandom_range(1, 40)) : cfg_d[k];
        dv[k] = (cur_d[k] != 0) && (cnt[k] >= cur_d[k]);
      end else begin
        if (cnt[k] == 0) dv[k] = 0;
        cnt[k] = 0;
      end
    end
  end

  assign map_draw_done   = dv[0];
  assign link_draw_done  = dv[1];
  assign enemy_draw_done = {dv[3], dv[2]};

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n  = 0;
    hp = 3'd7;
    while (!idle && n < 3000) begin
      c_start = 1'b1;
      @(negedge clock);
      n++;
    end
    c_start = 1'b0;
    check("reach_idle", 32'(idle), 32'd1);
  endtask

  task automatic restart();
    wait_idle();
    hp = 3'd0;
    @(negedge clock);
    hp      = 3'd7;
    c_start = 1'b1;
    repeat (3) @(negedge clock);
    c_start = 1'b0;
    check("restart_idle", 32'(idle), 32'd1);
  endtask

  // ---------------- frame scenario table ----------------
  typedef struct {
    int d_map, d_link, d_e0, d_e1;
    bit tick_link;
    bit fresh;
    int exp_len;
    bit exp_ovr, exp_tmo;
  } row_t;

  row_t rows[4];

  initial begin
    int  n;
    bit  sent;
    int  wait_n;

    rows[0] = '{1, 1, 1, 1, 1'b0, 1'b0, 6, 1'b0, 1'b0};
    rows[1] = '{300, 256, 256, 256, 1'b0, 1'b1, 1070, 1'b0, 1'b0};
    rows[2] = '{20, 20, 20, 20, 1'b1, 1'b1, 82, 1'b1, 1'b0};
    rows[3] = '{0, 5, 5, 5, 1'b0, 1'b0, 1017, 1'b1, 1'b1};

    repeat (3) @(negedge clock);
    check("reset_state", 32'(dut_vec), 32'(RESET_VEC));
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    check("wait_start_not_idle", 32'({init, idle}), 32'd0);
    c_start = 1'b1;
    @(negedge clock);
    c_start = 1'b0;
    check("idle_after_start", 32'(idle), 32'd1);

    for (int r = 0; r < 4; r++) begin
      if (rows[r].fresh) restart();
      cfg_d[0] = rows[r].d_map;
      cfg_d[1] = rows[r].d_link;
      cfg_d[2] = rows[r].d_e0;
      cfg_d[3] = rows[r].d_e1;
      frame_tick = 1'b1;
      n    = 0;
      sent = 0;
      while (n < 5000) begin
        @(negedge clock);
        frame_tick = 1'b0;
        if (idle) break;
        if (rows[r].tick_link && draw_link && !sent) begin
          frame_tick = 1'b1;
          sent = 1;
        end
        n++;
      end
      check("frame_len", 32'(n), 32'(rows[r].exp_len));
      check("overrun_flag", 32'(frame_overrun), 32'(rows[r].exp_ovr));
      check("timeout_flag", 32'(timeout_err), 32'(rows[r].exp_tmo));
      repeat (5) @(negedge clock);
      check("idle_hold", 32'({idle, reg_action}), 32'b10);
    end

    // hp==0 beats a simultaneous tick; restart clears both sticky flags.
    hp = 3'd0;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("game_over_on_hp0", 32'({game_over, reg_action, idle}), 32'b100);
    hp      = 3'd7;
    c_start = 1'b1;
    @(negedge clock);
    check("reinit_clears_flags", 32'({init, frame_overrun, timeout_err}), 32'b100);
    repeat (2) @(negedge clock);
    c_start = 1'b0;
    check("idle_after_restart", 32'(idle), 32'd1);

    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      frame_tick = ($urandom_range(0, 15) == 0);
      c_start    = ($urandom_range(0, 7) == 0);
      hp         = ($urandom_range(0, 30) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    end
    frame_tick = 1'b0;
    c_start    = 1'b0;
    hp         = 3'd7;
    rand_mode  = 0;

    // Asynchronous reset in the middle of an enemy draw.
    wait_idle();
    cfg_d[0] = 3; cfg_d[1] = 3; cfg_d[2] = 10; cfg_d[3] = 10;
    frame_tick = 1'b1;
    wait_n = 0;
    while (draw_enemy == '0 && wait_n < 200) begin
      @(negedge clock);
      frame_tick = 1'b0;
      wait_n++;
    end
    check("reached_enemy_draw", 32'(draw_enemy != '0), 32'd1);
    #2 resetn = 1'b0;
    #1 check("async_reset", 32'(dut_vec), 32'(RESET_VEC));
    @(negedge clock);
    resetn = 1'b1;
    check("init_after_release", 32'({init, draw_enemy, vga_sel}), 32'({1'b1, 2'b00, 2'b11}));
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
